// File: rtl/spi_regfile_periph_if.sv
// Pin-side SPI signals and fabric-side register bank outputs for spi_regfile_periph.
interface spi_regfile_periph_if #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
);
    logic                         SCLK;
    logic                         COPI;
    logic                         nCS;
    logic                         CIPO;
    logic                         cipo_oe;
    logic [NUM_REGS*DATA_W-1:0]   regs_q;
    logic                         wr_strobe;
    logic [ADDR_W-1:0]            wr_addr;
    logic                         frame_err;

    modport master (
        output SCLK, COPI, nCS,
        input  CIPO, cipo_oe, regs_q, wr_strobe, wr_addr, frame_err
    );

    modport slave (
        input  SCLK, COPI, nCS,
        output CIPO, cipo_oe, regs_q, wr_strobe, wr_addr, frame_err
    );
endinterface

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W control registers with
// write/read-back frames, a write strobe and a malformed-frame pulse.
module spi_regfile_periph #(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_regfile_periph_if.slave   bus
);
    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0]  CNT_ADDR    = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_ADDR_M1 = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT     = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0]   NREGS       = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_OVER} frame_state_e;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_copi_sync, r_ncs_sync;
    logic                   r_sclk_d, r_ncs_d;
    logic                   r_armed;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_W-1:0]     r_rx;
    logic [DATA_W-1:0]      r_tx;
    logic                   r_rd_frame;
    logic [DATA_W-1:0]      r_regs [NUM_REGS];
    logic [ADDR_W-1:0]      r_wr_addr;
    logic                   r_wr_strobe, r_frame_err;
    logic                   r_cipo, r_cipo_oe;

    logic                   w_sclk_s, w_copi_s, w_ncs_s;
    logic                   w_sclk_rise, w_sclk_fall, w_ncs_rise;
    logic [FRAME_W-1:0]     w_rx_next;
    logic                   w_shift_en, w_ld, w_tx_shift;
    logic [ADDR_W-1:0]      w_ld_addr;
    logic [DATA_W-1:0]      w_rd_data;
    logic                   w_cmt_rnw, w_cmt_legal, w_full;
    logic [ADDR_W-1:0]      w_cmt_addr;
    logic [DATA_W-1:0]      w_cmt_data;
    logic                   w_accept, w_reject, w_cipo_oe_nx;
    frame_state_e           w_state;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

    // Frame phase derived from the bit counter
    always_comb begin
        w_state = ST_IDLE;
        if (!w_ncs_s) begin
            if (r_cnt < CNT_ADDR)       w_state = ST_ADDR;
            else if (r_cnt < CNT_FRAME) w_state = ST_DATA;
            else                        w_state = ST_OVER;
        end
    end

    assign w_rx_next  = {r_rx[FRAME_W-2:0], w_copi_s};
    assign w_shift_en = w_sclk_rise & ~w_ncs_s & r_armed;
    assign w_ld_addr  = w_rx_next[ADDR_W-1:0];
    assign w_ld       = w_shift_en & (r_cnt == CNT_ADDR_M1) & ~w_rx_next[ADDR_W];
    // The falling edge right after the load keeps the MSB in place for the first data clock
    assign w_tx_shift = w_sclk_fall & (w_state == ST_DATA) & (r_cnt != CNT_ADDR);

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_ld_addr == ADDR_W'(i)) w_rd_data = r_regs[i];
        end
    end

    assign w_cmt_rnw   = r_rx[FRAME_W-1];
    assign w_cmt_addr  = r_rx[FRAME_W-2 -: ADDR_W];
    assign w_cmt_data  = r_rx[DATA_W-1:0];
    assign w_cmt_legal = {1'b0, w_cmt_addr} < NREGS;
    assign w_full      = (r_cnt == CNT_FRAME);
    assign w_accept    = w_ncs_rise & w_full & w_cmt_rnw & w_cmt_legal;
    assign w_reject    = w_ncs_rise & (r_cnt != '0) & ~(w_full & (~w_cmt_rnw | w_cmt_legal));

    assign w_cipo_oe_nx = ~w_ncs_s & r_rd_frame & (w_state == ST_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b0;
            r_armed     <= 1'b0;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_rd_frame  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.COPI};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], bus.nCS};
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;

            // A frame only counts once nCS has been seen idle since reset
            if (w_ncs_s) r_armed <= 1'b1;

            if (w_ncs_s) begin
                r_cnt      <= '0;
                r_rd_frame <= 1'b0;
            end else if (w_shift_en) begin
                r_rx <= w_rx_next;
                if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_ADDR_M1) r_rd_frame <= ~w_rx_next[ADDR_W];
            end

            if (w_ld)            r_tx <= w_rd_data;
            else if (w_tx_shift) r_tx <= {r_tx[DATA_W-2:0], 1'b0};

            r_cipo_oe   <= w_cipo_oe_nx;
            r_cipo      <= w_cipo_oe_nx & r_tx[DATA_W-1];
            r_wr_strobe <= w_accept;
            r_frame_err <= w_reject;

            if (w_accept) begin
                r_wr_addr <= w_cmt_addr;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (w_cmt_addr == ADDR_W'(i)) r_regs[i] <= w_cmt_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign bus.regs_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign bus.CIPO      = r_cipo;
    assign bus.cipo_oe   = r_cipo_oe;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_regfile_periph.sv
// Scoreboard bench for spi_regfile_periph: a 5x8 instance and a 16x16 instance
// share SCLK/COPI; each has its own nCS.
module tb_spi_regfile_periph;
    localparam int unsigned AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sclk = 1'b0, copi = 1'b0, ncs_a = 1'b1, ncs_b = 1'b1;

    spi_regfile_periph_if #(.NUM_REGS(5),  .DATA_W(8),  .ADDR_W(7)) ifa ();
    spi_regfile_periph_if #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(7)) ifb ();

    assign ifa.SCLK = sclk;
    assign ifa.COPI = copi;
    assign ifa.nCS  = ncs_a;
    assign ifb.SCLK = sclk;
    assign ifb.COPI = copi;
    assign ifb.nCS  = ncs_b;

    spi_regfile_periph #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_regfile_periph #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(7), .SYNC_STAGES(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        int           inst;
        bit           err;
        logic [6:0]   addr;
        logic [255:0] bank;
    } evt_t;

    evt_t        exp_evt[$];
    logic        exp_bit[$];
    logic [7:0]  model_a [5];
    logic [15:0] model_b [16];
    logic [6:0]  last_a, last_b;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endfunction

    function automatic logic [255:0] bank(int inst);
        logic [255:0] b = '0;
        if (inst == 0) for (int i = 0; i < 5; i++)  b[i*8 +: 8]   = model_a[i];
        else           for (int i = 0; i < 16; i++) b[i*16 +: 16] = model_b[i];
        return b;
    endfunction

    function automatic void push_evt(int inst, bit err);
        evt_t e;
        e.inst = inst;
        e.err  = err;
        e.addr = (inst == 0) ? last_a : last_b;
        e.bank = bank(inst);
        exp_evt.push_back(e);
    endfunction

    function automatic void clear_models();
        for (int i = 0; i < 5; i++)  model_a[i] = '0;
        for (int i = 0; i < 16; i++) model_b[i] = '0;
        last_a = '0;
        last_b = '0;
    endfunction

    // Event monitor: every strobe/error pulse must match the head of the queue
    function automatic void handle(int inst, logic stb, logic err, logic [6:0] wa, logic [255:0] q);
        evt_t e;
        if (exp_evt.size() == 0 || exp_evt[0].inst != inst) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse inst=%0d wr_strobe=%0b frame_err=%0b none expected", inst, stb, err);
        end else begin
            e = exp_evt.pop_front();
            check("wr_strobe", 256'(stb), 256'(!e.err));
            check("frame_err", 256'(err), 256'(e.err));
            check("wr_addr",   256'(wa),  256'(e.addr));
            check("regs_q",    q,         e.bank);
        end
    endfunction

    always @(negedge clk) begin
        if (ifa.wr_strobe || ifa.frame_err)
            handle(0, ifa.wr_strobe, ifa.frame_err, ifa.wr_addr, 256'(ifa.regs_q));
        if (ifb.wr_strobe || ifb.frame_err)
            handle(1, ifb.wr_strobe, ifb.frame_err, ifb.wr_addr, 256'(ifb.regs_q));
    end

    // CIPO monitor: controller samples on rising SCLK
    function automatic void cipo_chk(logic oe, logic d);
        logic b;
        if (oe) begin
            if (exp_bit.size() == 0) flag("cipo_oe_unexpected");
            else begin
                b = exp_bit.pop_front();
                check("cipo_bit", 256'(d), 256'(b));
            end
        end else begin
            check("cipo_idle", 256'(d), 256'(0));
            if (exp_bit.size() != 0) begin
                void'(exp_bit.pop_front());
                flag("cipo_oe_missing");
            end
        end
    endfunction

    always @(posedge sclk) begin
        if (!ncs_a)      cipo_chk(ifa.cipo_oe, ifa.CIPO);
        else if (!ncs_b) cipo_chk(ifb.cipo_oe, ifb.CIPO);
    end

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(logic b, bit rd, logic eb);
        copi = b;
        wait_clk(8);
        if (rd) exp_bit.push_back(eb);
        sclk = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
    endtask

    task automatic frame(int inst, logic [31:0] bits, int nbits, bit rd,
                         logic [15:0] rdat, int dw, int gap);
        bit inrd;
        int k;
        if (inst == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            inrd = rd && (i >= 1 + AW) && (i < 1 + AW + dw);
            k    = inrd ? (dw - 1 - (i - 1 - AW)) : 0;
            send_bit(bits[nbits-1-i], inrd, rdat[k]);
        end
        wait_clk(8);
        if (inst == 0) ncs_a = 1'b1; else ncs_b = 1'b1;
        wait_clk(gap);
        if (rd) check("cipo_bits_left", 256'(exp_bit.size()), 256'(0));
    endtask

    task automatic write_frame(int inst, logic [6:0] addr, logic [15:0] data, int gap);
        int          dw = (inst == 0) ? 8 : 16;
        int          nr = (inst == 0) ? 5 : 16;
        logic [31:0] f  = (32'(1) << (AW + dw)) | (32'(addr) << dw) | 32'(data);
        if (int'(addr) < nr) begin
            if (inst == 0) begin model_a[addr[2:0]] = data[7:0]; last_a = addr; end
            else           begin model_b[addr[3:0]] = data;      last_b = addr; end
            push_evt(inst, 1'b0);
        end else begin
            push_evt(inst, 1'b1);
        end
        frame(inst, f, 1 + AW + dw, 1'b0, 16'h0, dw, gap);
    endtask

    task automatic read_frame(int inst, logic [6:0] addr);
        int          dw = (inst == 0) ? 8 : 16;
        int          nr = (inst == 0) ? 5 : 16;
        logic [15:0] rd = '0;
        if (int'(addr) < nr) rd = (inst == 0) ? {8'h0, model_a[addr[2:0]]} : model_b[addr[3:0]];
        frame(inst, 32'(addr) << dw, 1 + AW + dw, 1'b1, rd, dw, 16);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_evt.size() != 0; i++) wait_clk(1);
        check("event_drain", 256'(exp_evt.size()), 256'(0));
    endtask

    initial begin
        logic [31:0] f;
        clear_models();
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);

        check("reset_regs_q",    256'(ifa.regs_q),    256'(0));
        check("reset_wr_addr",   256'(ifa.wr_addr),   256'(0));
        check("reset_cipo",      256'(ifa.CIPO),      256'(0));
        check("reset_cipo_oe",   256'(ifa.cipo_oe),   256'(0));
        check("reset_wr_strobe", 256'(ifa.wr_strobe), 256'(0));
        check("reset_frame_err", 256'(ifa.frame_err), 256'(0));

        // Basic write
        write_frame(0, 7'd0, 16'h00A5, 16);
        drain();
        check("reg0_after_write", 256'(ifa.regs_q[7:0]), 256'(8'hA5));

        // Write then read back the top legal address
        write_frame(0, 7'd4, 16'h003C, 16);
        read_frame(0, 7'd4);
        drain();

        // Out-of-range write rejected, out-of-range read returns zeros
        write_frame(0, 7'd5, 16'h00FF, 16);
        read_frame(0, 7'h7F);
        drain();

        // Truncated (12-bit) and over-long (17-bit) writes
        f = (32'(1) << 15) | (32'(2) << 8) | 32'h77;
        push_evt(0, 1'b1);
        frame(0, f >> 4, 12, 1'b0, 16'h0, 8, 16);
        push_evt(0, 1'b1);
        frame(0, (f << 1) | 32'h1, 17, 1'b0, 16'h0, 8, 16);
        drain();

        // Zero-bit nCS pulse is ignored
        ncs_a = 1'b0;
        wait_clk(8);
        ncs_a = 1'b1;
        wait_clk(16);

        // Back-to-back writes with nCS re-asserted almost immediately
        write_frame(0, 7'd2, 16'h0011, 2);
        write_frame(0, 7'd3, 16'h0022, 16);
        drain();
        read_frame(0, 7'd2);
        check("regs_after_b2b", 256'(ifa.regs_q), bank(0));

        // Reset after 9 bits of a write to addr 1
        f = (32'(1) << 15) | (32'(1) << 8) | 32'hAA;
        ncs_a = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 9; i++) send_bit(f[15-i], 1'b0, 1'b0);
        rst_n = 1'b0;
        clear_models();
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        check("regs_after_reset", 256'(ifa.regs_q), 256'(0));
        for (int i = 9; i < 12; i++) send_bit(f[15-i], 1'b0, 1'b0);
        wait_clk(8);
        ncs_a = 1'b1;
        wait_clk(16);
        write_frame(0, 7'd1, 16'h0055, 16);
        drain();
        check("reg1_after_reset_write", 256'(ifa.regs_q[15:8]), 256'(8'h55));

        // Wide instance: top register, read-back, first illegal address
        write_frame(1, 7'd15, 16'hBEEF, 16);
        drain();
        check("wide_reg15", 256'(ifb.regs_q[255:240]), 256'(16'hBEEF));
        read_frame(1, 7'd15);
        write_frame(1, 7'd16, 16'h1234, 16);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
